lcd_spi_tx: RTL and testbench
=============================

Name: lcd_spi_tx

Overview:
- Byte-level transmit engine for the 4-wire SPI LCD panel. Sits directly downstream of animation_controller, which hands it command/data bytes over a valid/ready handshake.
- Owns the panel hardware-reset sequence and backlight enable.
- Serialises each byte MSB-first in SPI mode 0 onto lcd_clk_out/lcd_data_out, with lcd_dc_out and lcd_cs_n_out framing.

Parameters:
- CLK_DIV, 2: SCLK half-period in clk cycles; legal range >=1.
- RST_LOW_CYCLES, 100000: clk cycles lcd_rst_n_out is held low after reset release.
- RST_WAIT_CYCLES, 12000000: clk cycles after lcd_rst_n_out rises before the first byte is accepted.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  byte offered by upstream.
- tx_ready  output  1  block can accept a byte this cycle; transfer occurs when tx_valid && tx_ready at a rising edge.
- tx_data  input  8  byte to send; latched at handshake.
- tx_dc  input  1  D/C level for this byte (0 = command, 1 = data); latched at handshake.
- init_done  output  1  panel reset sequence complete.
- busy  output  1  a byte is currently being shifted.
- lcd_rst_n_out  output  1  panel hardware reset, active low.
- lcd_bl_out  output  1  backlight enable.
- lcd_dc_out  output  1  panel D/C line.
- lcd_clk_out  output  1  SCLK; idles low.
- lcd_data_out  output  1  MOSI.
- lcd_cs_n_out  output  1  panel chip select, active low.

Behaviour:
- Reset (async, immediate) drives these values:
  - lcd_rst_n_out=0, lcd_bl_out=0, lcd_dc_out=0, lcd_clk_out=0, lcd_data_out=0, lcd_cs_n_out=1.
  - tx_ready=0, init_done=0, busy=0.
  - State RST_LOW; all counters 0.
- RST_LOW:
  - lcd_rst_n_out=0.
  - After RST_LOW_CYCLES cycles following rst deassertion, go to RST_WAIT; lcd_rst_n_out=1 from that edge.
- RST_WAIT: count RST_WAIT_CYCLES, then go to IDLE. From entry to IDLE onward, init_done=1 and lcd_bl_out=1 (both sticky until rst).
- IDLE:
  - cs_n=1, clk=0, tx_ready=1.
  - On handshake at edge T, latch tx_data/tx_dc and go to SHIFT. At T+1: cs_n=0, dc=tx_dc, data=bit7, clk=0, busy=1.
- SHIFT:
  - Each bit is CLK_DIV cycles with clk=0 (data stable), then CLK_DIV cycles with clk=1. Data changes only while clk is low, at bit boundaries.
  - A byte occupies exactly 16*CLK_DIV cycles.
- tx_ready in SHIFT is 1 only in the final cycle of bit 0's high phase; 0 otherwise.
- Handshake in that final cycle: load the next byte seamlessly. cs_n stays 0, dc updates to the new tx_dc, data=new bit7, clk=0 next cycle; no idle gap, no extra SCLK edge.
- No handshake in that final cycle: next cycle clk=0, cs_n=1, busy=0, state IDLE. dc and data hold their last values.
- tx_valid while tx_ready=0 (RST_LOW, RST_WAIT, mid-byte) is ignored. Upstream holds it; no byte is dropped or duplicated.
- tx_data/tx_dc changes after the handshake have no effect on the byte in flight.
- Counters are sized to hold max(RST_WAIT_CYCLES, RST_LOW_CYCLES) and CLK_DIV. Bit index counts 7 down to 0; no wrap beyond 0.
- rst asserted mid-byte or mid-init:
  - Abort immediately and drive reset values.
  - After release, rerun the full RST_LOW/RST_WAIT sequence.
  - The partial byte is never resumed.

Test Plan:
- Init sequence (RST_LOW_CYCLES=4, RST_WAIT_CYCLES=6, CLK_DIV=2), release rst -> lcd_rst_n_out low 4 cycles then high; 6 cycles later tx_ready=1, init_done=1, lcd_bl_out=1; cs_n=1 throughout.
- Single byte 0xA5, dc=1 (CLK_DIV=2):
  - cs_n low for exactly 32 cycles.
  - 8 SCLK rising edges, MOSI sampled at them = 1,0,1,0,0,1,0,1.
  - dc=1 stable while cs_n low.
  - cs_n=1 and clk=0 the cycle after the last high phase.
- Back-to-back 0x2A dc=0 then 0x00 dc=1, tx_valid held -> cs_n continuously low for 64 cycles; 16 rising edges; dc flips 0->1 exactly at the byte boundary; tx_ready pulses for one cycle at the end of byte 1.
- Handshake rejection:
  - tx_valid asserted during RST_WAIT and mid-byte -> not accepted.
  - Changing tx_data from 0xFF to 0x00 mid-byte -> remaining bits still follow 0xFF.
- Async rst asserted halfway through a byte -> outputs take reset values in the same cycle (cs_n=1, clk=0, rst_n=0). After release the full init sequence repeats before tx_ready returns.
- CLK_DIV=1, byte 0x81 -> SCLK period 2 cycles; byte spans 16 cycles; MOSI at rising edges = 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: SPI-mode-0 byte transmitter for the LCD panel.
// It also runs the panel hardware-reset sequence and enables the backlight once that sequence is done.
module lcd_spi_tx #(
    parameter int CLK_DIV         = 2,
    parameter int RST_LOW_CYCLES  = 100000,
    parameter int RST_WAIT_CYCLES = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rst_n_out,
    output logic       lcd_bl_out,
    output logic       lcd_dc_out,
    output logic       lcd_clk_out,
    output logic       lcd_data_out,
    output logic       lcd_cs_n_out
);
    localparam int MAXC = (RST_WAIT_CYCLES > RST_LOW_CYCLES) ? RST_WAIT_CYCLES : RST_LOW_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int DW   = $clog2(CLK_DIV + 1);

    localparam logic [1:0] S_RST_LOW  = 2'd0;
    localparam logic [1:0] S_RST_WAIT = 2'd1;
    localparam logic [1:0] S_IDLE     = 2'd2;
    localparam logic [1:0] S_SHIFT    = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div;
    logic          phase;
    logic [2:0]    bit_idx;
    logic [6:0]    shreg;
    logic          div_end;
    logic          take;

    assign div_end  = div == DW'(CLK_DIV - 1);
    assign tx_ready = (state == S_IDLE) || (state == S_SHIFT && phase && div_end && bit_idx == 3'd0);
    assign take     = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_RST_LOW;
            cnt           <= '0;
            div           <= '0;
            phase         <= 1'b0;
            bit_idx       <= 3'd0;
            shreg         <= 7'd0;
            init_done     <= 1'b0;
            busy          <= 1'b0;
            lcd_rst_n_out <= 1'b0;
            lcd_bl_out    <= 1'b0;
            lcd_dc_out    <= 1'b0;
            lcd_clk_out   <= 1'b0;
            lcd_data_out  <= 1'b0;
            lcd_cs_n_out  <= 1'b1;
        end else if (take) begin
            // A byte taken in the last high cycle follows on with no gap and no extra SCLK edge
            state        <= S_SHIFT;
            shreg        <= tx_data[6:0];
            lcd_dc_out   <= tx_dc;
            lcd_data_out <= tx_data[7];
            bit_idx      <= 3'd7;
            phase        <= 1'b0;
            div          <= '0;
            lcd_clk_out  <= 1'b0;
            lcd_cs_n_out <= 1'b0;
            busy         <= 1'b1;
        end else begin
            case (state)
                S_RST_LOW: begin
                    cnt <= (cnt == CW'(RST_LOW_CYCLES - 1)) ? '0 : cnt + 1'b1;
                    if (cnt == CW'(RST_LOW_CYCLES - 1)) begin
                        state         <= S_RST_WAIT;
                        lcd_rst_n_out <= 1'b1;
                    end
                end
                S_RST_WAIT: begin
                    cnt <= (cnt == CW'(RST_WAIT_CYCLES - 1)) ? '0 : cnt + 1'b1;
                    if (cnt == CW'(RST_WAIT_CYCLES - 1)) begin
                        state      <= S_IDLE;
                        init_done  <= 1'b1;
                        lcd_bl_out <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    div <= div_end ? '0 : div + 1'b1;
                    if (div_end && !phase) begin
                        phase       <= 1'b1;
                        lcd_clk_out <= 1'b1;
                    end else if (div_end) begin
                        phase       <= 1'b0;
                        lcd_clk_out <= 1'b0;
                        if (bit_idx == 3'd0) begin
                            state        <= S_IDLE;
                            lcd_cs_n_out <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            bit_idx      <= bit_idx - 1'b1;
                            lcd_data_out <= shreg[6];
                            shreg        <= {shreg[5:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb_lcd_spi_tx: randomized scoreboard bench that decodes the SPI pins and compares each byte to what was offered.
// A second instance with CLK_DIV=1 checks the fastest SCLK.
module tb_lcd_spi_tx;
    localparam int CD = 2, LOW = 4, WAIT = 6;

    logic clk = 1'b0, rst = 1'b1;
    logic tx_valid = 1'b0, tx_dc = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_ready, init_done, busy, rst_n, bl, dc, sclk, mosi, cs_n;

    logic rst1 = 1'b1, tx_valid1 = 1'b0, tx_dc1 = 1'b0;
    logic [7:0] tx_data1 = 8'h00;
    logic tx_ready1, init_done1, busy1, rst_n1, bl1, dc1, sclk1, mosi1, cs_n1;

    int compared = 0, mismatched = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    lcd_spi_tx #(.CLK_DIV(CD), .RST_LOW_CYCLES(LOW), .RST_WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_dc(tx_dc), .init_done(init_done), .busy(busy), .lcd_rst_n_out(rst_n),
        .lcd_bl_out(bl), .lcd_dc_out(dc), .lcd_clk_out(sclk), .lcd_data_out(mosi),
        .lcd_cs_n_out(cs_n)
    );

    lcd_spi_tx #(.CLK_DIV(1), .RST_LOW_CYCLES(LOW), .RST_WAIT_CYCLES(WAIT)) dut1 (
        .clk(clk), .rst(rst1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
        .tx_dc(tx_dc1), .init_done(init_done1), .busy(busy1), .lcd_rst_n_out(rst_n1),
        .lcd_bl_out(bl1), .lcd_dc_out(dc1), .lcd_clk_out(sclk1), .lcd_data_out(mosi1),
        .lcd_cs_n_out(cs_n1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer a byte at a negedge; the expectation is queued only when the handshake will occur.
    task automatic send(input logic [7:0] b, input logic d);
        logic ok;
        ok = 1'b0;
        tx_valid = 1'b1;
        tx_data  = b;
        tx_dc    = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (tx_ready) begin
                exp_q.push_back({d, b});
                ok = 1'b1;
            end
            @(negedge clk);
        end
        chk("handshake_taken", ok, 1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = tx_ready && cs_n && !busy;
        end
        chk("reached_idle", ok, 1);
    endtask

    task automatic check_init();
        for (int i = 0; i <= LOW + WAIT; i++) begin
            chk("init_rst_n", rst_n, i >= LOW);
            chk("init_ready", tx_ready, i >= LOW + WAIT);
            chk("init_done", init_done, i >= LOW + WAIT);
            chk("init_bl", bl, i >= LOW + WAIT);
            chk("init_cs_n", cs_n, 1);
            if (i == LOW + 1) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
                tx_dc    = 1'b1;
            end
            if (i < LOW + WAIT) @(negedge clk);
        end
    endtask

    // Monitor: decode SCLK rising edges while CS is low and score each completed byte.
    logic psclk = 1'b0, pcs = 1'b1;
    logic [7:0] sh;
    int bits = 0, run = 0, rdy = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            exp_q.delete();
            bits = 0;
            run  = 0;
            rdy  = 0;
        end else begin
            if (!cs_n) begin
                run++;
                if (tx_ready) rdy++;
            end
            if (!cs_n && sclk && !psclk) begin
                sh = {sh[6:0], mosi};
                bits++;
                if (exp_q.size() > 0) chk("dc_at_edge", dc, exp_q[0][8]);
                if (bits % 8 == 0) begin
                    chk("byte_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("byte_value", sh, e[7:0]);
                    end
                end
            end
            if (cs_n && !pcs) begin
                chk("cs_low_cycles", run, bits * 2 * CD);
                chk("ready_pulses", rdy, bits / 8);
                chk("sclk_idle_after", sclk, 0);
                bits = 0;
                run  = 0;
                rdy  = 0;
            end
        end
        psclk = sclk;
        pcs   = cs_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got1;
        int low1, rise1;
        logic ps1, seen;
        @(negedge clk);
        chk("rst_rst_n", rst_n, 0);
        chk("rst_bl", bl, 0);
        chk("rst_dc", dc, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_ready", tx_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 0);
        rst  = 1'b0;
        rst1 = 1'b0;
        check_init();
        send(8'h3C, 1'b1);
        tx_valid = 1'b0;
        wait_idle();

        send(8'hA5, 1'b1);
        tx_valid = 1'b0;
        chk("busy_in_byte", busy, 1);
        wait_idle();

        send(8'h2A, 1'b0);
        send(8'h00, 1'b1);
        tx_valid = 1'b0;
        wait_idle();

        send(8'hFF, 1'b1);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        send(8'h00, 1'b0);
        tx_valid = 1'b0;
        wait_idle();

        repeat (20) begin
            int gap;
            send(8'($urandom), 1'($urandom));
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                tx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        tx_valid = 1'b0;
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        send(8'h5A, 1'b1);
        tx_valid = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_rst_n", rst_n, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", tx_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_init();
        send(8'hC3, 1'b0);
        tx_valid = 1'b0;
        wait_idle();
        chk("queue_drained_end", exp_q.size(), 0);

        tx_data1  = 8'h81;
        tx_dc1    = 1'b1;
        tx_valid1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            seen = tx_ready1;
            @(negedge clk);
        end
        tx_valid1 = 1'b0;
        tx_data1  = 8'h00;
        got1 = 8'h00;
        low1 = 0;
        rise1 = 0;
        ps1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!cs_n1) low1++;
            if (!cs_n1 && sclk1 && !ps1) begin
                got1 = {got1[6:0], mosi1};
                rise1++;
            end
            ps1 = sclk1;
            @(negedge clk);
        end
        chk("div1_accepted", seen, 1);
        chk("div1_byte", got1, 8'h81);
        chk("div1_cs_low", low1, 16);
        chk("div1_rises", rise1, 8);
        chk("div1_dc", dc1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
